// File: rtl/phy_reg_write_scheduler.sv
// Write-side front end for the physical register file: queues producer results and drains them onto the write ports.
// Optional stall counter output (stallCycles) is enabled by defining PHY_REG_WRITE_STALL_STATS_EN.
module phy_reg_write_scheduler #(
    parameter int ENTRY_NUM   = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int SRC_NUM     = 4,
    parameter int WRITE_NUM   = 2,
    parameter int QUEUE_DEPTH = 8,
    localparam int IDX = $clog2(ENTRY_NUM),
    localparam int QW  = $clog2(QUEUE_DEPTH),
    localparam int CW  = QW + 1,
    localparam int VW  = DATA_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          initStart,
    output logic                          initBusy,
    input  logic [SRC_NUM-1:0]            srcValid,
    input  logic [SRC_NUM*IDX-1:0]        srcRegNum,
    input  logic [SRC_NUM*DATA_WIDTH-1:0] srcData,
    output logic                          inReady,
    output logic [WRITE_NUM-1:0]          we,
    output logic [WRITE_NUM*IDX-1:0]      wa,
    output logic [WRITE_NUM*VW-1:0]       wv,
    output logic [CW-1:0]                 pendingCount
`ifdef PHY_REG_WRITE_STALL_STATS_EN
    ,
    output logic [31:0]                   stallCycles
`endif
);

    localparam int SW = IDX + 1;

    typedef enum logic {
        CLEAR,
        IDLE
    } stateT;

    stateT           stateReg;
    logic [SW-1:0]   idxReg;
    logic [QW-1:0]   headReg;
    logic [QW-1:0]   tailReg;
    logic [CW-1:0]   countReg;

    logic [IDX-1:0]        qAddr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] qData [QUEUE_DEPTH];

    logic [QW-1:0]         candPtr  [WRITE_NUM];
    logic [IDX-1:0]        candAddr [WRITE_NUM];
    logic [DATA_WIDTH-1:0] candData [WRITE_NUM];

    logic [WRITE_NUM-1:0]  issue;
    logic [CW-1:0]         deqCount;
    logic                  drainBlocked;

    logic [QW-1:0]         laneSlot [SRC_NUM];
    logic [CW-1:0]         enqCount;
    logic                  enqEn;
    logic [CW-1:0]         enqAccepted;

    assign initBusy     = (stateReg == CLEAR);
    assign inReady      = (stateReg == IDLE) && ((CW'(QUEUE_DEPTH) - countReg) >= CW'(SRC_NUM));
    assign pendingCount = countReg;

    assign enqEn       = inReady && !initStart;
    assign enqAccepted = enqEn ? enqCount : '0;

    // Drain candidates are the oldest WRITE_NUM slots starting at head.
    for (genvar gi = 0; gi < WRITE_NUM; gi++) begin : gCand
        assign candPtr[gi]  = headReg + QW'(gi);
        assign candAddr[gi] = qAddr[candPtr[gi]];
        assign candData[gi] = qData[candPtr[gi]];
    end

    // Issue a prefix of the candidates, stopping at the first address repeated within the group.
    always_comb begin
        issue        = '0;
        deqCount     = '0;
        drainBlocked = 1'b0;
        if (stateReg == IDLE && !initStart) begin
            for (int k = 0; k < WRITE_NUM; k++) begin
                if (CW'(k) >= countReg) begin
                    drainBlocked = 1'b1;
                end
                for (int j = 0; j < k; j++) begin
                    if (candAddr[j] == candAddr[k]) begin
                        drainBlocked = 1'b1;
                    end
                end
                if (!drainBlocked) begin
                    issue[k] = 1'b1;
                    deqCount = deqCount + CW'(1);
                end
            end
        end
    end

    // Valid lanes are packed in ascending lane order starting at tail.
    always_comb begin
        enqCount = '0;
        for (int l = 0; l < SRC_NUM; l++) begin
            laneSlot[l] = tailReg + QW'(enqCount);
            if (srcValid[l]) begin
                enqCount = enqCount + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enqEn) begin
            for (int l = 0; l < SRC_NUM; l++) begin
                if (srcValid[l]) begin
                    qAddr[laneSlot[l]] <= srcRegNum[l*IDX +: IDX];
                    qData[laneSlot[l]] <= srcData[l*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= CLEAR;
            idxReg   <= '0;
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            we       <= '0;
            wa       <= '0;
            wv       <= '0;
        end else if (initStart) begin
            // Queued results are discarded; the sweep restarts on the next cycle.
            stateReg <= CLEAR;
            idxReg   <= '0;
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            we       <= '0;
        end else if (stateReg == CLEAR) begin
            for (int i = 0; i < WRITE_NUM; i++) begin
                we[i]              <= (int'(idxReg) + i) < ENTRY_NUM;
                wa[i*IDX +: IDX]   <= IDX'(int'(idxReg) + i);
                wv[i*VW +: VW]     <= {1'b1, {DATA_WIDTH{1'b0}}};
            end
            idxReg <= idxReg + SW'(WRITE_NUM);
            if ((int'(idxReg) + WRITE_NUM) >= ENTRY_NUM) begin
                stateReg <= IDLE;
            end
        end else begin
            for (int k = 0; k < WRITE_NUM; k++) begin
                we[k] <= issue[k];
                if (issue[k]) begin
                    wa[k*IDX +: IDX] <= candAddr[k];
                    wv[k*VW +: VW]   <= {1'b1, candData[k]};
                end
            end
            headReg  <= headReg + QW'(deqCount);
            tailReg  <= tailReg + QW'(enqAccepted);
            countReg <= countReg + enqAccepted - deqCount;
        end
    end

`ifdef PHY_REG_WRITE_STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles <= '0;
        end else if (initStart) begin
            stallCycles <= '0;
        end else if (stateReg == IDLE && (|srcValid) && !inReady && stallCycles != 32'hFFFF_FFFF) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_reg_write_scheduler.sv
// Directed bench for phy_reg_write_scheduler: reset sweep, partial sweep, compaction, hazard, backpressure, re-init.
module tb_phy_reg_write_scheduler;

    logic         clk;
    logic         rst;
    logic         initStart;
    logic         initBusy;
    logic [3:0]   srcValid;
    logic [23:0]  srcRegNum;
    logic [127:0] srcData;
    logic         inReady;
    logic [1:0]   we;
    logic [11:0]  wa;
    logic [65:0]  wv;
    logic [3:0]   pendingCount;

    logic         initBusy5;
    logic         inReady5;
    logic [1:0]   we5;
    logic [5:0]   wa5;
    logic [65:0]  wv5;
    logic [3:0]   pendingCount5;

`ifdef PHY_REG_WRITE_STALL_STATS_EN
    logic [31:0]  stallCycles;
    logic [31:0]  stallCycles5;
`endif

    int vectors = 0;
    int miscompares = 0;

    phy_reg_write_scheduler dut (
        .clk(clk), .rst(rst), .initStart(initStart), .initBusy(initBusy),
        .srcValid(srcValid), .srcRegNum(srcRegNum), .srcData(srcData),
        .inReady(inReady), .we(we), .wa(wa), .wv(wv), .pendingCount(pendingCount)
`ifdef PHY_REG_WRITE_STALL_STATS_EN
        , .stallCycles(stallCycles)
`endif
    );

    phy_reg_write_scheduler #(.ENTRY_NUM(5)) dut5 (
        .clk(clk), .rst(rst), .initStart(1'b0), .initBusy(initBusy5),
        .srcValid(4'b0000), .srcRegNum(12'h000), .srcData(128'h0),
        .inReady(inReady5), .we(we5), .wa(wa5), .wv(wv5), .pendingCount(pendingCount5)
`ifdef PHY_REG_WRITE_STALL_STATS_EN
        , .stallCycles(stallCycles5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // 32 sweep cycles on the 64-entry instance; optionally also the 5-entry instance's 3-cycle sweep.
    task automatic runSweep(input bit withSmall);
        logic [65:0] wvClear;
        wvClear = {1'b1, 32'h0, 1'b1, 32'h0};
        for (int c = 0; c < 32; c++) begin
            tick();
            $display("sweep cycle %0d: we=%b wa=%h initBusy=%b", c, we, wa, initBusy);
            check("sweep_we", we, 2'b11);
            check("sweep_wa", wa, {6'(2*c+1), 6'(2*c)});
            check("sweep_wv", wv, wvClear);
            if (c == 0) check("sweep_busy_first", initBusy, 1'b1);
            if (c == 30) check("sweep_busy_last", initBusy, 1'b1);
            if (c == 31) begin
                check("sweep_busy_done", initBusy, 1'b0);
                check("sweep_ready_done", inReady, 1'b1);
            end
            if (withSmall) begin
                case (c)
                    0: begin check("small_we0", we5, 2'b11); check("small_wa0", wa5, {3'd1, 3'd0}); end
                    1: begin check("small_we1", we5, 2'b11); check("small_wa1", wa5, {3'd3, 3'd2}); end
                    2: begin check("small_we2", we5, 2'b01); check("small_wa2", wa5[2:0], 3'd4);
                             check("small_busy2", initBusy5, 1'b0); end
                    3: check("small_we3", we5, 2'b00);
                    default: ;
                endcase
            end
        end
    endtask

    logic [5:0]  sbAddr[$];
    logic [31:0] sbData[$];
    int          cntM;
    int          deqM;
    int          seq;
    int          stallM;
    logic [1:0]  expWe;
    bit          accepted;
    logic [5:0]  popAddr;
    logic [31:0] popData;

    initial begin
        rst = 1'b1;
        initStart = 1'b0;
        srcValid = '0;
        srcRegNum = '0;
        srcData = '0;

        // Reset state
        tick();
        tick();
        $display("reset: we=%b wa=%h initBusy=%b inReady=%b count=%0d", we, wa, initBusy, inReady, pendingCount);
        check("rst_we", we, 2'b00);
        check("rst_wa", wa, 12'h0);
        check("rst_wv", wv, 66'h0);
        check("rst_busy", initBusy, 1'b1);
        check("rst_ready", inReady, 1'b0);
        check("rst_count", pendingCount, 4'd0);
        rst = 1'b0;

        runSweep(1'b1);
        tick();
        check("idle_we", we, 2'b00);

        // Lane compaction: lanes 1 and 3 land on ports 0 and 1
        srcValid = 4'b1010;
        srcRegNum[11:6] = 6'd7;   srcData[63:32]  = 32'h11;
        srcRegNum[23:18] = 6'd9;  srcData[127:96] = 32'h33;
        tick();
        srcValid = '0;
        check("comp_count", pendingCount, 4'd2);
        check("comp_we_early", we, 2'b00);
        tick();
        $display("compaction: we=%b wa=%h wv=%h", we, wa, wv);
        check("comp_we", we, 2'b11);
        check("comp_wa", wa, {6'd9, 6'd7});
        check("comp_wv", wv, {1'b1, 32'h33, 1'b1, 32'h11});
        check("comp_count_after", pendingCount, 4'd0);
        tick();
        check("comp_we_idle", we, 2'b00);

        // Same-address hazard: two writes to reg 5 serialise in lane order
        srcValid = 4'b0011;
        srcRegNum[5:0] = 6'd5;  srcData[31:0]  = 32'hA;
        srcRegNum[11:6] = 6'd5; srcData[63:32] = 32'hB;
        tick();
        srcValid = '0;
        tick();
        $display("hazard 1: we=%b wa0=%0d wv0=%h", we, wa[5:0], wv[32:0]);
        check("haz_we1", we, 2'b01);
        check("haz_wa1", wa[5:0], 6'd5);
        check("haz_wv1", wv[32:0], {1'b1, 32'hA});
        tick();
        $display("hazard 2: we=%b wa0=%0d wv0=%h", we, wa[5:0], wv[32:0]);
        check("haz_we2", we, 2'b01);
        check("haz_wa2", wa[5:0], 6'd5);
        check("haz_wv2", wv[32:0], {1'b1, 32'hB});
        tick();
        check("haz_we3", we, 2'b00);

        // Backpressure and pointer wrap with an occupancy model and in-order scoreboard
        cntM = 0; expWe = 2'b00; seq = 0; stallM = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            $display("bp cycle %0d: count=%0d inReady=%b we=%b wa=%h", cyc, pendingCount, inReady, we, wa);
            check("bp_count", pendingCount, 4'(cntM));
            check("bp_ready", inReady, cntM <= 4);
            check("bp_we", we, expWe);
            for (int k = 0; k < 2; k++) begin
                if (expWe[k] && sbAddr.size() > 0) begin
                    popAddr = sbAddr.pop_front();
                    popData = sbData.pop_front();
                    check("bp_wa", wa[k*6 +: 6], popAddr);
                    check("bp_wv", wv[k*33 +: 33], {1'b1, popData});
                end
            end
            accepted = 1'b0;
            if (cyc < 20) begin
                srcValid = 4'hF;
                for (int l = 0; l < 4; l++) begin
                    srcRegNum[l*6 +: 6] = 6'(((seq + l) % 50) + 10);
                    srcData[l*32 +: 32] = 32'h1000 + 32'(seq + l);
                end
                accepted = (cntM <= 4);
                if (accepted) begin
                    for (int l = 0; l < 4; l++) begin
                        sbAddr.push_back(6'(((seq + l) % 50) + 10));
                        sbData.push_back(32'h1000 + 32'(seq + l));
                    end
                    seq += 4;
                end else begin
                    stallM++;
                end
            end else begin
                srcValid = '0;
            end
            deqM  = (cntM < 2) ? cntM : 2;
            cntM  = cntM + (accepted ? 4 : 0) - deqM;
            expWe = (deqM == 2) ? 2'b11 : ((deqM == 1) ? 2'b01 : 2'b00);
            tick();
        end
        check("bp_all_drained", sbAddr.size(), 0);
        check("bp_final_count", pendingCount, 4'd0);
`ifdef PHY_REG_WRITE_STALL_STATS_EN
        check("bp_stall_cycles", stallCycles, 32'(stallM));
`endif

        // initStart with six queued entries: nothing queued is ever written
        srcValid = 4'hF;
        for (int l = 0; l < 4; l++) begin
            srcRegNum[l*6 +: 6] = 6'd20;
            srcData[l*32 +: 32] = 32'hBEEF0000 + 32'(l);
        end
        tick();
        check("init_pre_count4", pendingCount, 4'd4);
        srcValid = 4'b0111;
        for (int l = 0; l < 3; l++) srcData[l*32 +: 32] = 32'hBEEF0004 + 32'(l);
        tick();
        srcValid = '0;
        $display("pre-init: count=%0d we=%b wa0=%0d wv0=%h", pendingCount, we, wa[5:0], wv[32:0]);
        check("init_pre_count6", pendingCount, 4'd6);
        check("init_pre_we", we, 2'b01);
        check("init_pre_wv", wv[32:0], {1'b1, 32'hBEEF0000});
        initStart = 1'b1;
        tick();
        initStart = 1'b0;
        $display("post-init: count=%0d busy=%b ready=%b we=%b", pendingCount, initBusy, inReady, we);
        check("init_count", pendingCount, 4'd0);
        check("init_busy", initBusy, 1'b1);
        check("init_ready", inReady, 1'b0);
        check("init_we", we, 2'b00);
`ifdef PHY_REG_WRITE_STALL_STATS_EN
        check("init_stall_cleared", stallCycles, 32'd0);
`endif
        runSweep(1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_init_we", we, 2'b00);
            check("post_init_count", pendingCount, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phy_reg_write_scheduler.md
Name: phy_reg_write_scheduler

Overview:
- Write-side front end for the physical register file.
- Collects results from SRC_NUM producer pipelines into a circular queue and drains them, oldest first, onto WRITE_NUM registered write ports.
- Never issues two writes to the same entry in one cycle.
- Owns the post-reset clear sweep, which writes data 0 / valid 1 to every entry; the zero register depends on this sweep.

Parameters:
- ENTRY_NUM, 64: physical register entries; IDX = $clog2(ENTRY_NUM).
- DATA_WIDTH, 32: data bits per entry, excluding the valid bit.
- SRC_NUM, 4: producer result ports.
- WRITE_NUM, 2: register-file write ports driven. Constraint: WRITE_NUM <= SRC_NUM.
- QUEUE_DEPTH, 8: queue entries. Constraints: power of 2, QUEUE_DEPTH >= SRC_NUM.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- initStart, in, 1: one-cycle pulse; flushes the queue and restarts the clear sweep.
- initBusy, out, 1: high while the clear sweep runs.
- srcValid, in, SRC_NUM: per-producer result valid.
- srcRegNum, in, SRC_NUM*IDX: destination entry per producer.
- srcData, in, SRC_NUM*DATA_WIDTH: result data per producer.
- inReady, out, 1: all srcValid lanes are accepted this cycle.
- we, out, WRITE_NUM: write enable per port.
- wa, out, WRITE_NUM*IDX: write address per port.
- wv, out, WRITE_NUM*(DATA_WIDTH+1): write value per port; MSB is the valid bit.
- pendingCount, out, $clog2(QUEUE_DEPTH)+1: current queue occupancy.

Behaviour:
- Reset (async):
  - State = CLEAR, sweep index = 0, queue empty (head = tail = 0).
  - Outputs: we = 0, wa = 0, wv = 0, initBusy = 1, inReady = 0, pendingCount = 0.
- State CLEAR:
  - Each cycle registers a write on every port i: address idx+i, data 0, valid bit 1, we[i] = (idx+i < ENTRY_NUM).
  - idx advances by WRITE_NUM each cycle.
  - Transition to IDLE on the cycle the writes for idx+WRITE_NUM >= ENTRY_NUM are issued.
  - Sweep length is ceil(ENTRY_NUM/WRITE_NUM) cycles. The final partial group masks out-of-range ports.
  - The queue neither enqueues nor drains; inReady = 0.
- State IDLE:
  - initBusy = 0; normal enqueue and drain.
  - initStart in any state: queue flushed, idx = 0, enter CLEAR next cycle.
  - initStart during CLEAR restarts the sweep at 0.
  - Writes in flight on the registered outputs this cycle still complete.
- inReady is combinational from registered occupancy: inReady = (state == IDLE) && (QUEUE_DEPTH - count >= SRC_NUM). Same-cycle drain is not credited.
- Enqueue:
  - Valid lanes are compacted in ascending lane index into tail, tail+1, …
  - Lanes offered while inReady = 0 are dropped; producers must hold them.
- Drain:
  - Candidates are head .. head+min(count, WRITE_NUM)-1.
  - Candidate k issues on port k unless its address equals an address of an earlier candidate this cycle. Draining stops at the first such conflict; later candidates wait.
  - Issued entries are registered onto we/wa/wv: 1-cycle latency from dequeue, minimum 2 cycles from srcValid to we.
  - Ports not issuing: we = 0; wa/wv hold their previous values.
- Occupancy arithmetic:
  - Head and tail are log2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
  - count_next = count + enq - deq. Simultaneous enqueue and drain are allowed in one cycle.
- Ordering: writes to the same entry reach the register file in enqueue order (lane order within a cycle, then cycle order).
- Full queue: inReady = 0, drain continues.
- Empty queue: all we = 0.

Optional Feature:
- Macro: PHY_REG_WRITE_STALL_STATS_EN.
- When defined:
  - Adds output stallCycles, 32 bits, reset 0.
  - Increments in each cycle where state == IDLE, |srcValid, and !inReady.
  - Saturates at 0xFFFFFFFF.
  - Cleared by initStart.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset sweep, ENTRY_NUM=64, WRITE_NUM=2: release rst. Expect 32 cycles of we = 2'b11 with wa pairs (0,1) … (62,63) and wv = {1'b1, 32'h0}; then initBusy falls and inReady rises.
- Partial final group, ENTRY_NUM=5, WRITE_NUM=2: sweep writes (0,1), (2,3), then 4 with we = 2'b01, over 3 cycles total.
- Lane compaction: in IDLE, srcValid = 4'b1010 with lane1 → reg 7 / data 0x11 and lane3 → reg 9 / data 0x33. Two cycles later expect we = 2'b11, wa = (7, 9), wv data = (0x11, 0x33).
- Same-address hazard: enqueue reg 5 = 0xA on lane0 and reg 5 = 0xB on lane1 in one cycle. Expect one cycle with only port0 writing 5 ← 0xA, then the next cycle port0 writing 5 ← 0xB. Never two writes to 5 in one cycle.
- Backpressure and wrap, QUEUE_DEPTH=8, SRC_NUM=4:
  - Offer 4 valid lanes every cycle for 20 cycles.
  - Expect inReady to toggle whenever count > 4 and pendingCount never to exceed 8.
  - Expect all accepted writes to emerge in order across pointer wrap, and no dropped accepted result.
- initStart mid-operation: with 6 queued entries, pulse initStart. Expect pendingCount = 0 next cycle, initBusy = 1, a sweep restarting at address 0, and none of the 6 entries ever written. With PHY_REG_WRITE_STALL_STATS_EN defined, stallCycles reads 0 after the pulse.
